// File: rtl/nrm_pkg.sv
// Shared FPU normaliser definitions: FSM states, shifter ops and exponent limits.
// Mantissa vectors are [40:0] with [40] holding the overflow position (bit -1).
package nrm_pkg;

  localparam int         MANT_W  = 40;
  localparam logic [7:0] EXP_MAX = 8'h7F;
  localparam logic [7:0] EXP_MIN = 8'h80;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EVAL = 2'd1,
    FIN  = 2'd2
  } nrm_state_e;

  typedef enum logic [1:0] {
    SH_HOLD = 2'd0,
    SH_LOAD = 2'd1,
    SH_LEFT = 2'd2,
    SH_ASR  = 2'd3
  } sh_op_e;

endpackage

// File: rtl/nrm_shreg.sv
// 41-bit mantissa shift register (load / shift-left zero-fill / arithmetic shift-right)
// with the zero, overflow and already-normalised flags the FSM decides on.
import nrm_pkg::*;

module nrm_shreg (
  input  logic          clk_sys,
  input  logic          clr,
  input  sh_op_e        op,
  input  logic [40:0]   d,
  output logic [40:0]   r,
  output logic          is_zero,
  output logic          ovf,
  output logic          norm
);

  always_ff @(posedge clk_sys) begin
    if (clr) begin
      r <= '0;
    end else begin
      case (op)
        SH_LOAD: r <= d;
        SH_LEFT: r <= {r[39:0], 1'b0};
        SH_ASR:  r <= {r[40], r[40:1]};
        default: r <= r;
      endcase
    end
  end

  assign is_zero = (r == '0);
  assign ovf     = r[40] ^ r[39];
  assign norm    = r[39] ^ r[38];

endmodule

// File: rtl/nrm.sv
// Mantissa normaliser: at most one right shift or up to 39 left shifts, exponent tracked per shift.
// Port bit [MSB] corresponds to the leftmost FPU bit (m_in[40] = bit -1, t[39] = bit 0).
//
// state | meaning
// IDLE  | waiting for start; previous results held
// EVAL  | one normalisation decision per cycle
// FIN   | done pulse, results valid
import nrm_pkg::*;

module nrm (
  input  logic              clk_sys,
  input  logic              _0_nrm,
  input  logic              start,
  input  logic [40:0]       m_in,
  input  logic [7:0]        e_in,
  output logic              busy,
  output logic              done,
  output logic [MANT_W-1:0] t,
  output logic [7:0]        e_out,
  output logic              zero,
  output logic              of,
  output logic              uf
);

  nrm_state_e  state, state_nx;
  sh_op_e      sh_op;
  logic [40:0] r;
  logic [7:0]  x;
  logic        is_zero, ovf, norm;
  logic        ld, eval;
  logic        at_min;

  assign at_min = (x == EXP_MIN);

  nrm_shreg u_shreg (
    .clk_sys (clk_sys),
    .clr     (_0_nrm),
    .op      (sh_op),
    .d       (m_in),
    .r       (r),
    .is_zero (is_zero),
    .ovf     (ovf),
    .norm    (norm)
  );

  always_ff @(posedge clk_sys) begin
    if (_0_nrm) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (start) state_nx = EVAL;
      EVAL:    if (is_zero || ovf || norm || at_min) state_nx = FIN;
      FIN:     state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    busy  = 1'b0;
    done  = 1'b0;
    ld    = 1'b0;
    eval  = 1'b0;
    sh_op = SH_HOLD;
    case (state)
      IDLE: begin
        if (start) begin
          ld    = 1'b1;
          sh_op = SH_LOAD;
        end
      end
      EVAL: begin
        busy = 1'b1;
        eval = 1'b1;
        if (!is_zero) begin
          if (ovf)                  sh_op = SH_ASR;
          else if (!norm && !at_min) sh_op = SH_LEFT;
        end
      end
      FIN:     done = 1'b1;
      default: ;
    endcase
  end

  // Exponent counter and result registers; the saturation checks keep x from wrapping.
  always_ff @(posedge clk_sys) begin
    if (_0_nrm) begin
      x     <= '0;
      t     <= '0;
      e_out <= '0;
      zero  <= 1'b0;
      of    <= 1'b0;
      uf    <= 1'b0;
    end else if (ld) begin
      x    <= e_in;
      zero <= 1'b0;
      of   <= 1'b0;
      uf   <= 1'b0;
    end else if (eval) begin
      if (is_zero) begin
        t     <= '0;
        e_out <= '0;
        zero  <= 1'b1;
      end else if (ovf) begin
        t <= r[40:1];
        if (x == EXP_MAX) begin
          of    <= 1'b1;
          e_out <= EXP_MAX;
        end else begin
          e_out <= x + 8'd1;
        end
      end else if (norm) begin
        t     <= r[39:0];
        e_out <= x;
      end else if (at_min) begin
        t     <= '0;
        e_out <= '0;
        zero  <= 1'b1;
        uf    <= 1'b1;
      end else begin
        x <= x - 8'd1;
      end
    end
  end

endmodule
